// File: rtl/ahbl_cmd_master_if.sv
// Command/response and AHB-Lite bundle for the single-outstanding AHB-Lite master.
interface ahbl_cmd_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_timeout;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  HREADY, HRDATA,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_timeout,
    output HADDR, HTRANS, HWRITE, HSIZE, HWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output HREADY, HRDATA,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_timeout,
    input  HADDR, HTRANS, HWRITE, HSIZE, HWDATA
  );
endinterface

// File: rtl/ahbl_cmd_master.sv
// AHB-Lite master: one word command at a time, address then data phase,
// with a per-phase HREADY-low watchdog that aborts a hung transfer.
module ahbl_cmd_master #(
  parameter int TIMEOUT = 16
) (
  input logic               HCLK,
  input logic               HRESET,
  ahbl_cmd_master_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_RESP
  } state_t;

  localparam logic [1:0] HT_IDLE = 2'b00;
  localparam logic [1:0] HT_NSEQ = 2'b10;
  localparam bit         TO_EN   = (TIMEOUT > 0);
  localparam int         CW      = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] C_MAX  = CW'(TIMEOUT);
  localparam logic [CW-1:0] C_LAST = CW'(TO_EN ? TIMEOUT - 1 : 0);

  state_t        r_state;
  logic          r_ready;
  logic          r_wr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_haddr;
  logic [1:0]    r_htrans;
  logic          r_hwrite;
  logic [31:0]   r_hwdata;
  logic          r_rsp_valid;
  logic [31:0]   r_rsp_rdata;
  logic          r_rsp_to;
  logic [CW-1:0] r_cnt;

  logic          w_expire;
  logic [CW-1:0] w_cnt_inc;

  // Abort on the edge that would make the count reach TIMEOUT.
  assign w_expire  = TO_EN && !bus.HREADY && (r_cnt == C_LAST);
  assign w_cnt_inc = (r_cnt == C_MAX) ? r_cnt : r_cnt + 1'b1;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state     <= S_IDLE;
      r_ready     <= 1'b0;
      r_wr        <= 1'b0;
      r_wdata     <= '0;
      r_haddr     <= '0;
      r_htrans    <= HT_IDLE;
      r_hwrite    <= 1'b0;
      r_hwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_to    <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (r_ready && bus.cmd_valid) begin
            r_ready  <= 1'b0;
            r_wr     <= bus.cmd_write;
            r_wdata  <= bus.cmd_wdata;
            r_haddr  <= bus.cmd_addr;
            r_hwrite <= bus.cmd_write;
            r_htrans <= HT_NSEQ;
            r_cnt    <= '0;
            r_state  <= S_ADDR;
          end else begin
            r_ready <= 1'b1;
          end
        end
        S_ADDR: begin
          if (bus.HREADY) begin
            r_htrans <= HT_IDLE;
            r_haddr  <= '0;
            r_hwrite <= 1'b0;
            r_hwdata <= r_wr ? r_wdata : 32'h0;
            r_cnt    <= '0;
            r_state  <= S_DATA;
          end else if (w_expire) begin
            r_htrans    <= HT_IDLE;
            r_haddr     <= '0;
            r_hwrite    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= '0;
            r_rsp_to    <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_DATA: begin
          if (bus.HREADY) begin
            r_hwdata    <= '0;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= r_wr ? 32'h0 : bus.HRDATA;
            r_rsp_to    <= 1'b0;
            r_state     <= S_RESP;
          end else if (w_expire) begin
            r_hwdata    <= '0;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= '0;
            r_rsp_to    <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_RESP: begin
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready   = r_ready;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_rdata   = r_rsp_rdata;
  assign bus.rsp_timeout = r_rsp_to;
  assign bus.HADDR       = r_haddr;
  assign bus.HTRANS      = r_htrans;
  assign bus.HWRITE      = r_hwrite;
  assign bus.HSIZE       = 3'b010;
  assign bus.HWDATA      = r_hwdata;

endmodule

// File: tb/tb_ahbl_cmd_master.sv
// Directed bench for ahbl_cmd_master: expected responses queued at issue,
// checked by an independent response monitor.
module tb_ahbl_cmd_master;
  localparam int TO = 4;

  logic HCLK;
  logic HRESET;
  ahbl_cmd_master_if bus ();

  ahbl_cmd_master #(.TIMEOUT(TO)) dut (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .bus    (bus)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        to;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_acc = 0;
  bit hold_chk = 0;
  logic [31:0] hold_val;
  logic        hold_to;

  initial HCLK = 0;
  always #5 HCLK = ~HCLK;
  always @(posedge HCLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h cyc=%0d", nm, act, exp, cyc);
    end
  endtask

  // Response monitor
  always @(negedge HCLK) begin
    if (!HRESET) begin
      if (hold_chk && !bus.rsp_valid) begin
        chk("rsp_rdata_hold", bus.rsp_rdata, hold_val);
        chk("rsp_to_hold", {31'b0, bus.rsp_timeout}, {31'b0, hold_to});
      end
      hold_chk = 0;
      if (bus.rsp_valid) begin
        if (q.size() == 0) begin
          chk("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("rsp_rdata", bus.rsp_rdata, e.rdata);
          chk("rsp_timeout", {31'b0, bus.rsp_timeout}, {31'b0, e.to});
          chk("rsp_cycle", cyc, e.cyc);
          hold_chk = 1;
          hold_val = e.rdata;
          hold_to  = e.to;
        end
      end
    end
  end

  task automatic run(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] rd, input int aw, input int dw,
                     input bit bp);
    bit   to;
    int   ca, cd, k;
    exp_t e;
    to = (aw >= TO) || (dw >= TO);
    ca = (aw >= TO) ? TO : aw + 1;
    cd = (aw >= TO) ? 0 : ((dw >= TO) ? TO : dw + 1);
    k = 0;
    while (!bus.cmd_ready && k < 20) begin
      @(negedge HCLK);
      k++;
    end
    if (!bus.cmd_ready) chk("ready_wait", 32'd0, 32'd1);
    bus.cmd_valid = 1;
    bus.cmd_write = wr;
    bus.cmd_addr  = a;
    bus.cmd_wdata = wd;
    bus.HREADY    = 1;
    bus.HRDATA    = 32'hBAD0_0000;
    last_acc = cyc + 1;
    e.rdata = (wr || to) ? 32'h0 : rd;
    e.to    = to;
    e.cyc   = last_acc + ca + cd;
    q.push_back(e);
    @(negedge HCLK);
    if (!bp) bus.cmd_valid = 0;
    for (int i = 0; i < ca; i++) begin
      chk("addr_htrans", {30'b0, bus.HTRANS}, 32'd2);
      chk("addr_haddr", bus.HADDR, a);
      chk("addr_hwrite", {31'b0, bus.HWRITE}, {31'b0, wr});
      chk("addr_ready", {31'b0, bus.cmd_ready}, 32'd0);
      bus.cmd_addr  = 32'hF000_0000 | i;
      bus.cmd_write = ~wr;
      bus.HREADY    = (i == aw);
      bus.HRDATA    = 32'hBAD1_0000 | i;
      @(negedge HCLK);
    end
    for (int j = 0; j < cd; j++) begin
      chk("data_htrans", {30'b0, bus.HTRANS}, 32'd0);
      chk("data_haddr", bus.HADDR, 32'h0);
      chk("data_hwdata", bus.HWDATA, wr ? wd : 32'h0);
      bus.cmd_addr = 32'hE000_0000 | j;
      bus.HREADY   = (j == dw);
      bus.HRDATA   = (j == dw) ? rd : (32'hBAD2_0000 | j);
      @(negedge HCLK);
    end
    bus.HREADY = 1;
    chk("resp_htrans", {30'b0, bus.HTRANS}, 32'd0);
    chk("resp_hwdata", bus.HWDATA, 32'h0);
    chk("resp_ready", {31'b0, bus.cmd_ready}, 32'd0);
    @(negedge HCLK);
    chk("post_ready", {31'b0, bus.cmd_ready}, 32'd1);
  endtask

  initial begin
    int a1;
    HRESET        = 1;
    bus.cmd_valid = 0;
    bus.cmd_write = 0;
    bus.cmd_addr  = 0;
    bus.cmd_wdata = 0;
    bus.HREADY    = 1;
    bus.HRDATA    = 0;
    @(negedge HCLK);
    chk("rst_ready", {31'b0, bus.cmd_ready}, 32'd0);
    chk("rst_htrans", {30'b0, bus.HTRANS}, 32'd0);
    chk("rst_haddr", bus.HADDR, 32'h0);
    chk("rst_hwdata", bus.HWDATA, 32'h0);
    chk("rst_rsp", {30'b0, bus.rsp_valid, bus.rsp_timeout}, 32'd0);
    chk("rst_rdata", bus.rsp_rdata, 32'h0);
    chk("hsize", {29'b0, bus.HSIZE}, 32'd2);
    HRESET = 0;
    @(negedge HCLK);
    chk("rel_ready", {31'b0, bus.cmd_ready}, 32'd1);

    run(1, 32'h0100_0000, 32'hDEAD_BEEF, 32'h0, 0, 0, 0);
    run(0, 32'h0000_0040, 32'h5555_5555, 32'h1234_5678, 0, 0, 0);
    run(0, 32'h2000_0010, 32'h0, 32'hA5A5_0F0F, 3, 2, 0);
    run(1, 32'h2000_0020, 32'hCAFE_F00D, 32'h0, 3, 3, 0);
    run(0, 32'h3000_0000, 32'h0, 32'hFFFF_FFFF, 0, 99, 0);
    run(1, 32'h3000_0004, 32'h1111_2222, 32'h0, 99, 0, 0);
    run(0, 32'h4000_0000, 32'h0, 32'h0BAD_CAFE, 0, 0, 1);
    a1 = last_acc;
    run(1, 32'h4000_0004, 32'h7777_8888, 32'h0, 0, 0, 1);
    chk("b2b_gap1", last_acc - a1, 32'd4);
    a1 = last_acc;
    run(0, 32'h4000_0008, 32'h0, 32'h600D_D00D, 0, 0, 1);
    chk("b2b_gap2", last_acc - a1, 32'd4);
    bus.cmd_valid = 0;

    // Reset in the data phase of a write
    @(negedge HCLK);
    bus.cmd_valid = 1;
    bus.cmd_write = 1;
    bus.cmd_addr  = 32'h5000_0000;
    bus.cmd_wdata = 32'h9999_AAAA;
    bus.HREADY    = 1;
    @(negedge HCLK);
    bus.cmd_valid = 0;
    chk("rm_addr", bus.HADDR, 32'h5000_0000);
    @(negedge HCLK);
    bus.HREADY = 0;
    chk("rm_hwdata", bus.HWDATA, 32'h9999_AAAA);
    HRESET = 1;
    #1;
    chk("rm_htrans", {30'b0, bus.HTRANS}, 32'd0);
    chk("rm_hwdata0", bus.HWDATA, 32'h0);
    chk("rm_ready", {31'b0, bus.cmd_ready}, 32'd0);
    chk("rm_rsp", {31'b0, bus.rsp_valid}, 32'd0);
    @(negedge HCLK);
    @(negedge HCLK);
    HRESET = 0;
    bus.HREADY = 1;
    @(negedge HCLK);
    chk("rm_rel_ready", {31'b0, bus.cmd_ready}, 32'd1);
    chk("rm_rel_rsp", {31'b0, bus.rsp_valid}, 32'd0);

    run(0, 32'h6000_0000, 32'h0, 32'h0F1E_2D3C, 1, 0, 0);
    repeat (3) @(negedge HCLK);
    chk("queue_empty", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end
endmodule
